// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request path: channel encodings, field widths,
// the request header carried through the queue and a saturating-increment helper.
package l2_pkg;

  localparam logic [1:0] CHANNEL_A = 2'b00;
  localparam logic [1:0] CHANNEL_C = 2'b01;

  localparam int OP_W = 3;

  // Width-independent part of a queued request; address/source widths are
  // module parameters, so the top level wraps this into the full entry.
  typedef struct packed {
    logic            channel;    // 0 = A, 1 = C
    logic [1:0]      master_id;
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] param;
  } req_hdr_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/l2_sync_fifo.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage with wrapping pointers and an
// explicit occupancy count. Caller must never push when full or pop when empty.
module l2_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/l2_request_queue.sv
// In-order request queue behind the L2 arbiter with one slot held back for Channel C.
// Optional enqueue/stall counters are built when L2_REQ_QUEUE_STATS_EN is defined.
module l2_request_queue
  import l2_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int SRC_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // Arbiter side: a grant moves on the edge where arb_valid_i && arb_ready_o.
  input  logic                       arb_valid_i,
  input  logic [1:0]                 arb_channel_i,
  input  logic [1:0]                 arb_master_id_i,
  output logic                       arb_ready_o,
  input  logic [4*OP_W-1:0]          a_opcode_i,
  input  logic [4*OP_W-1:0]          a_param_i,
  input  logic [4*ADDR_W-1:0]        a_address_i,
  input  logic [4*SRC_W-1:0]         a_source_i,
  input  logic [4*OP_W-1:0]          c_opcode_i,
  input  logic [4*OP_W-1:0]          c_param_i,
  input  logic [4*ADDR_W-1:0]        c_address_i,
  input  logic [4*SRC_W-1:0]         c_source_i,
  // Pipeline side: head moves on the edge where req_valid_o && req_ready_i.
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic                       req_channel_o,
  output logic [1:0]                 req_master_id_o,
  output logic [OP_W-1:0]            req_opcode_o,
  output logic [OP_W-1:0]            req_param_o,
  output logic [ADDR_W-1:0]          req_address_o,
  output logic [SRC_W-1:0]           req_source_o,
`ifdef L2_REQ_QUEUE_STATS_EN
  output logic [15:0]                stat_a_enq_o,
  output logic [15:0]                stat_c_enq_o,
  output logic [15:0]                stat_stall_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH-1);

  typedef struct packed {
    req_hdr_t          hdr;
    logic [ADDR_W-1:0] address;
    logic [SRC_W-1:0]  source;
  } req_entry_t;

  localparam int ENTRY_W = $bits(req_entry_t);

  req_entry_t       wr_entry;
  req_entry_t       head;
  logic [ENTRY_W-1:0] rd_data;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;
  logic             arb_ready;
  int unsigned      sel;

  always_comb begin
    sel      = 32'(arb_master_id_i);
    wr_entry = '0;
    wr_entry.hdr.channel   = (arb_channel_i == CHANNEL_C);
    wr_entry.hdr.master_id = arb_master_id_i;
    if (arb_channel_i == CHANNEL_C) begin
      wr_entry.hdr.opcode = c_opcode_i[sel*OP_W +: OP_W];
      wr_entry.hdr.param  = c_param_i[sel*OP_W +: OP_W];
      wr_entry.address    = c_address_i[sel*ADDR_W +: ADDR_W];
      wr_entry.source     = c_source_i[sel*SRC_W +: SRC_W];
    end else begin
      wr_entry.hdr.opcode = a_opcode_i[sel*OP_W +: OP_W];
      wr_entry.hdr.param  = a_param_i[sel*OP_W +: OP_W];
      wr_entry.address    = a_address_i[sel*ADDR_W +: ADDR_W];
      wr_entry.source     = a_source_i[sel*SRC_W +: SRC_W];
    end
  end

  // A stops one short of full so a Release can always land behind a backlog of Acquires.
  always_comb begin
    arb_ready = 1'b0;
    case (arb_channel_i)
      CHANNEL_A: arb_ready = (count < DEPTH_M1_C);
      CHANNEL_C: arb_ready = (count < DEPTH_C);
      default:   arb_ready = 1'b0;
    endcase
  end

  assign enq = arb_valid_i && arb_ready;
  assign deq = req_valid_o && req_ready_i;

  l2_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (enq),
    .wdata_i (wr_entry),
    .pop_i   (deq),
    .rdata_o (rd_data),
    .count_o (count)
  );

  assign head            = req_entry_t'(rd_data);
  assign arb_ready_o     = arb_ready;
  assign req_valid_o     = (count != '0);
  assign req_channel_o   = head.hdr.channel;
  assign req_master_id_o = head.hdr.master_id;
  assign req_opcode_o    = head.hdr.opcode;
  assign req_param_o     = head.hdr.param;
  assign req_address_o   = head.address;
  assign req_source_o    = head.source;
  assign count_o         = count;

`ifdef L2_REQ_QUEUE_STATS_EN
  logic [15:0] stat_a_q, stat_a_d;
  logic [15:0] stat_c_q, stat_c_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_a_d     = sat_inc16(stat_a_q, enq && (arb_channel_i == CHANNEL_A));
    stat_c_d     = sat_inc16(stat_c_q, enq && (arb_channel_i == CHANNEL_C));
    stat_stall_d = sat_inc16(stat_stall_q, arb_valid_i && !arb_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_q     <= '0;
      stat_c_q     <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_a_q     <= stat_a_d;
      stat_c_q     <= stat_c_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_a_enq_o = stat_a_q;
  assign stat_c_enq_o = stat_c_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_l2_request_queue.sv
// Directed bench for l2_request_queue (DEPTH=4): C reservation, full/drain timing,
// pointer wrap, illegal channel and asynchronous reset.
module tb_l2_request_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int SRC_W  = 4;
  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_C = 2'b01;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              arb_valid_i;
  logic [1:0]        arb_channel_i;
  logic [1:0]        arb_master_id_i;
  logic              arb_ready_o;
  logic [11:0]       a_opcode_i, a_param_i, c_opcode_i, c_param_i;
  logic [4*ADDR_W-1:0] a_address_i, c_address_i;
  logic [4*SRC_W-1:0]  a_source_i, c_source_i;
  logic              req_valid_o;
  logic              req_ready_i;
  logic              req_channel_o;
  logic [1:0]        req_master_id_o;
  logic [2:0]        req_opcode_o;
  logic [2:0]        req_param_o;
  logic [ADDR_W-1:0] req_address_o;
  logic [SRC_W-1:0]  req_source_o;
  logic [2:0]        count_o;
`ifdef L2_REQ_QUEUE_STATS_EN
  logic [15:0]       stat_a_enq_o, stat_c_enq_o, stat_stall_o;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [ADDR_W-1:0] exp_q[$];

  l2_request_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SRC_W(SRC_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arb_valid_i     (arb_valid_i),
    .arb_channel_i   (arb_channel_i),
    .arb_master_id_i (arb_master_id_i),
    .arb_ready_o     (arb_ready_o),
    .a_opcode_i      (a_opcode_i),
    .a_param_i       (a_param_i),
    .a_address_i     (a_address_i),
    .a_source_i      (a_source_i),
    .c_opcode_i      (c_opcode_i),
    .c_param_i       (c_param_i),
    .c_address_i     (c_address_i),
    .c_source_i      (c_source_i),
    .req_valid_o     (req_valid_o),
    .req_ready_i     (req_ready_i),
    .req_channel_o   (req_channel_o),
    .req_master_id_o (req_master_id_o),
    .req_opcode_o    (req_opcode_o),
    .req_param_o     (req_param_o),
    .req_address_o   (req_address_o),
    .req_source_o    (req_source_o),
`ifdef L2_REQ_QUEUE_STATS_EN
    .stat_a_enq_o    (stat_a_enq_o),
    .stat_c_enq_o    (stat_c_enq_o),
    .stat_stall_o    (stat_stall_o),
`endif
    .count_o         (count_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Non-selected slots carry distinct filler so a wrong mux select is visible.
  task automatic set_background();
    for (int m = 0; m < 4; m++) begin
      a_opcode_i[m*3 +: 3]       = 3'(m);
      a_param_i[m*3 +: 3]        = 3'(3 - m);
      a_address_i[m*32 +: 32]    = 32'hA000_0000 | 32'(m);
      a_source_i[m*4 +: 4]       = 4'(m + 8);
      c_opcode_i[m*3 +: 3]       = 3'(m + 4);
      c_param_i[m*3 +: 3]        = 3'(m + 1);
      c_address_i[m*32 +: 32]    = 32'hC000_0000 | 32'(m);
      c_source_i[m*4 +: 4]       = 4'(m + 4);
    end
  endtask

  task automatic drive_grant(input logic v, input logic [1:0] ch, input logic [1:0] mid,
                             input logic [2:0] op, input logic [2:0] prm,
                             input logic [31:0] addr, input logic [3:0] src);
    set_background();
    arb_valid_i     = v;
    arb_channel_i   = ch;
    arb_master_id_i = mid;
    if (ch == CH_C) begin
      c_opcode_i[int'(mid)*3 +: 3]   = op;
      c_param_i[int'(mid)*3 +: 3]    = prm;
      c_address_i[int'(mid)*32 +: 32] = addr;
      c_source_i[int'(mid)*4 +: 4]   = src;
    end else begin
      a_opcode_i[int'(mid)*3 +: 3]   = op;
      a_param_i[int'(mid)*3 +: 3]    = prm;
      a_address_i[int'(mid)*32 +: 32] = addr;
      a_source_i[int'(mid)*4 +: 4]   = src;
    end
    #1;
  endtask

  task automatic idle_arb();
    arb_valid_i = 1'b0;
    #1;
  endtask

  task automatic expect_head(input string tag, input logic ch, input logic [1:0] mid,
                             input logic [2:0] op, input logic [2:0] prm,
                             input logic [31:0] addr, input logic [3:0] src);
    check({tag, ".valid"}, 64'(req_valid_o), 64'(1'b1));
    check({tag, ".chan"},  64'(req_channel_o), 64'(ch));
    check({tag, ".mid"},   64'(req_master_id_o), 64'(mid));
    check({tag, ".op"},    64'(req_opcode_o), 64'(op));
    check({tag, ".param"}, 64'(req_param_o), 64'(prm));
    check({tag, ".addr"},  64'(req_address_o), 64'(addr));
    check({tag, ".src"},   64'(req_source_o), 64'(src));
  endtask

  initial begin
    rst_n = 1'b0;
    req_ready_i = 1'b0;
    arb_valid_i = 1'b0;
    arb_channel_i = CH_A;
    arb_master_id_i = 2'd0;
    set_background();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // reset state
    check("rst.valid", 64'(req_valid_o), 64'd0);
    check("rst.count", 64'(count_o), 64'd0);
    check("rst.ready_a", 64'(arb_ready_o), 64'd1);

    // single C grant, master 2
    drive_grant(1'b1, CH_C, 2'd2, 3'd7, 3'd1, 32'h0000_1000, 4'd5);
    check("t1.ready", 64'(arb_ready_o), 64'd1);
    tick();
    idle_arb();
    check("t1.count", 64'(count_o), 64'd1);
    expect_head("t1.head", 1'b1, 2'd2, 3'd7, 3'd1, 32'h0000_1000, 4'd5);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("t1.drain_count", 64'(count_o), 64'd0);
    check("t1.drain_valid", 64'(req_valid_o), 64'd0);

    // four A grants: last one blocked by the C reservation
    drive_grant(1'b1, CH_A, 2'd0, 3'd4, 3'd0, 32'h100, 4'd0);
    check("t2.rdy0", 64'(arb_ready_o), 64'd1);
    tick();
    drive_grant(1'b1, CH_A, 2'd1, 3'd4, 3'd1, 32'h101, 4'd1);
    check("t2.rdy1", 64'(arb_ready_o), 64'd1);
    tick();
    drive_grant(1'b1, CH_A, 2'd3, 3'd4, 3'd2, 32'h102, 4'd2);
    check("t2.rdy2", 64'(arb_ready_o), 64'd1);
    tick();
    drive_grant(1'b1, CH_A, 2'd2, 3'd4, 3'd3, 32'h103, 4'd3);
    check("t2.count3", 64'(count_o), 64'd3);
    check("t2.rdy3_blocked", 64'(arb_ready_o), 64'd0);
    tick();
    check("t2.count_hold", 64'(count_o), 64'd3);
    drive_grant(1'b1, CH_C, 2'd1, 3'd6, 3'd0, 32'h200, 4'd6);
    check("t2.rdy_c", 64'(arb_ready_o), 64'd1);
    tick();
    check("t2.count4", 64'(count_o), 64'd4);
    drive_grant(1'b1, CH_C, 2'd0, 3'd5, 3'd2, 32'h201, 4'd7);
    check("t2.rdy_c_full", 64'(arb_ready_o), 64'd0);

    // full queue drains one while the C grant waits
    expect_head("t3.head_a0", 1'b0, 2'd0, 3'd4, 3'd0, 32'h100, 4'd0);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("t3.count_after_pop", 64'(count_o), 64'd3);
    check("t3.rdy_c_now", 64'(arb_ready_o), 64'd1);
    tick();
    idle_arb();
    check("t3.count_refill", 64'(count_o), 64'd4);
    req_ready_i = 1'b1;
    expect_head("t3.head_a1", 1'b0, 2'd1, 3'd4, 3'd1, 32'h101, 4'd1);
    tick();
    expect_head("t3.head_a2", 1'b0, 2'd3, 3'd4, 3'd2, 32'h102, 4'd2);
    tick();
    expect_head("t3.head_c0", 1'b1, 2'd1, 3'd6, 3'd0, 32'h200, 4'd6);
    tick();
    expect_head("t3.head_c1", 1'b1, 2'd0, 3'd5, 3'd2, 32'h201, 4'd7);
    tick();
    req_ready_i = 1'b0;
    check("t3.empty", 64'(count_o), 64'd0);

    // streaming: one entry in flight, 10 more through, pointers wrap
    drive_grant(1'b1, CH_A, 2'd0, 3'd1, 3'd0, 32'h300, 4'd0);
    tick();
    exp_q.push_back(32'h300);
    req_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive_grant(1'b1, (i % 3 == 0) ? CH_C : CH_A, 2'(i % 4), 3'(i), 3'(i % 5),
                  32'h300 + 32'(i), 4'(i));
      check($sformatf("t4.rdy%0d", i), 64'(arb_ready_o), 64'd1);
      check($sformatf("t4.head%0d", i), 64'(req_address_o), 64'(exp_q.pop_front()));
      tick();
      exp_q.push_back(32'h300 + 32'(i));
      check($sformatf("t4.count%0d", i), 64'(count_o), 64'd1);
    end
    idle_arb();
    expect_head("t4.last", 1'b0, 2'd2, 3'd2, 3'd0, 32'h30A, 4'd10);
    tick();
    req_ready_i = 1'b0;
    check("t4.empty", 64'(count_o), 64'd0);

    // illegal channel is never accepted
    drive_grant(1'b1, 2'd2, 2'd1, 3'd3, 3'd3, 32'h400, 4'd1);
    check("t5.rdy", 64'(arb_ready_o), 64'd0);
    tick();
    idle_arb();
    check("t5.count", 64'(count_o), 64'd0);
    check("t5.valid", 64'(req_valid_o), 64'd0);

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive_grant(1'b1, CH_A, 2'(i), 3'd2, 3'd0, 32'h500 + 32'(i), 4'(i));
      tick();
    end
    drive_grant(1'b0, CH_A, 2'd0, 3'd0, 3'd0, 32'h0, 4'd0);
    check("t6.pre_count", 64'(count_o), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_valid", 64'(req_valid_o), 64'd0);
    check("t6.rst_count", 64'(count_o), 64'd0);
    check("t6.rst_ready", 64'(arb_ready_o), 64'd1);
`ifdef L2_REQ_QUEUE_STATS_EN
    check("t6.stat_a", 64'(stat_a_enq_o), 64'd0);
    check("t6.stat_c", 64'(stat_c_enq_o), 64'd0);
    check("t6.stat_stall", 64'(stat_stall_o), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    drive_grant(1'b1, CH_C, 2'd3, 3'd6, 3'd4, 32'h600, 4'd9);
    tick();
    idle_arb();
    check("t6.post_count", 64'(count_o), 64'd1);
    expect_head("t6.post_head", 1'b1, 2'd3, 3'd6, 3'd4, 32'h600, 4'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/l2_request_queue.md
Name: l2_request_queue

Overview:
- Sits directly downstream of the L2 request arbiter. On each accepted arbiter grant it captures the selected master's Channel A or C payload into an in-order FIFO.
- The FIFO feeds the L2 directory lookup pipeline.
- It reserves one slot for Channel C, so Release/ReleaseData traffic can always make forward progress past a backlog of Acquire/Get requests (deadlock avoidance).

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: address width.
- SRC_W, 4: TileLink source ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- arb_valid_i  in  1  arbiter grant valid
- arb_channel_i  in  2  granted channel: 0 = A, 1 = C
- arb_master_id_i  in  2  granted master index
- arb_ready_o  out  1  queue accepts the current grant
- a_opcode_i  in  12  packed {m3,m2,m1,m0} Channel A opcodes
- a_param_i  in  12  packed Channel A params
- a_address_i  in  4*ADDR_W  packed Channel A addresses
- a_source_i  in  4*SRC_W  packed Channel A sources
- c_opcode_i  in  12  packed Channel C opcodes
- c_param_i  in  12  packed Channel C params
- c_address_i  in  4*ADDR_W  packed Channel C addresses
- c_source_i  in  4*SRC_W  packed Channel C sources
- req_valid_o  out  1  head entry valid
- req_ready_i  in  1  pipeline consumes head entry
- req_channel_o  out  1  head channel: 0 = A, 1 = C
- req_master_id_o  out  2  head master
- req_opcode_o  out  3  head opcode
- req_param_o  out  3  head param
- req_address_o  out  ADDR_W  head address
- req_source_o  out  SRC_W  head source
- count_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Enqueue occurs when arb_valid_i && arb_ready_o at a clk edge.
  - Payload is muxed from the master selected by arb_master_id_i on the channel selected by arb_channel_i.
  - The entry stores {channel, master_id, opcode, param, address, source}.
- arb_ready_o is combinational from the registered count and arb_channel_i:
  - Channel C: ready = (count < DEPTH).
  - Channel A: ready = (count < DEPTH-1). The last slot is reserved for C.
  - arb_channel_i of 2 or 3: ready = 0; the grant is never accepted.
- Dequeue occurs when req_valid_o && req_ready_i.
  - req_valid_o = (count != 0).
  - req_* outputs are driven from the head entry register. They are stable while valid && !ready.
- Latency: an entry enqueued at edge N is visible on req_* after edge N (earliest consume at edge N+1). There is no combinational bypass from arb to req.
- Simultaneous enqueue and dequeue:
  - count unchanged; both pointers advance.
  - Readiness uses the pre-edge count, so a full queue never accepts in the same cycle it drains.
- Pointers:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately; full = (count == DEPTH).
- Ordering: strict FIFO across both channels.
- Reset (asynchronous, any time):
  - count = 0, pointers = 0, req_valid_o = 0, arb_ready_o reflects empty.
  - Entry storage is not reset; req_* payload outputs are don't-care while req_valid_o = 0.
  - In-flight entries are discarded.

Optional Feature:
- Macro: L2_REQ_QUEUE_STATS_EN.
- When defined, adds three outputs, each 16-bit and saturating at 16'hFFFF, cleared by reset:
  - stat_a_enq_o: count of Channel A enqueues.
  - stat_c_enq_o: count of Channel C enqueues.
  - stat_stall_o: count of cycles with arb_valid_i && !arb_ready_o.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package l2_pkg holds:
  - CHANNEL_A = 2'b00, CHANNEL_C = 2'b01.
  - Opcode/param width constant (3).
  - The request-entry struct/typedef {channel, master_id, opcode, param, address, source}.
- One sub-module: l2_sync_fifo. It is a generic depth/width storage with pointers and count. The top level holds the payload mux, the C-reservation readiness logic and the stats counters.

Test Plan:
- Reset, then grant C, master 2, opcode 3'd7, address 0x1000 -> arb_ready_o = 1; the next cycle req_valid_o = 1, req_channel_o = 1, req_master_id_o = 2, req_address_o = 0x1000; count_o = 1.
- DEPTH = 4: four back-to-back A grants with req_ready_i = 0 -> first three accepted; fourth sees arb_ready_o = 0 at count_o = 3. A C grant is then accepted, giving count_o = 4, and a further C grant sees ready = 0.
- Full queue, C grant pending, req_ready_i = 1 for one cycle -> head pops and count_o drops 4 -> 3. The C grant is accepted only on the following edge. Order is preserved (A0, A1, A2, C0).
- Continuous enqueue/dequeue of 10 entries with DEPTH = 4 -> pointers wrap; outputs appear in issue order; count_o stays at 1.
- arb_channel_i = 2 with arb_valid_i = 1 -> arb_ready_o = 0; no enqueue; count_o unchanged.
- Assert rst_n low mid-stream at count_o = 3 -> req_valid_o = 0 and count_o = 0 immediately. With L2_REQ_QUEUE_STATS_EN defined, all stats read 0 after reset.
